// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: serializes IF fetches and MEM-stage data accesses
// onto one fixed-latency synchronous memory and drives the pipeline stalls.
module mem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0] STRK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        own_dm_q, own_dm_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        dm_ready_q, dm_ready_d;
    logic        grant_dm;

    // Data wins unless a waiting fetch has been passed over MAX_D_STREAK times.
    assign grant_dm = dm_req & ~(if_req & (streak_q == STRK_MAX));

    // Next-state and output decode for the access sequencer.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        own_dm_d    = own_dm_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dm_req || if_req) begin
                    state_d     = ISSUE;
                    mem_en_d    = 1'b1;
                    own_dm_d    = grant_dm;
                    mem_we_d    = grant_dm & dm_we;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : 32'd0;
                    if (grant_dm && if_req) begin
                        if (streak_q != STRK_MAX)
                            streak_d = streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 4'd0;
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = DONE;
                    if (own_dm_q) begin
                        dm_ready_d = 1'b1;
                        if (!mem_we_q)
                            dm_rdata_d = mem_rdata;
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            cnt_q       <= 4'd0;
            own_dm_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            own_dm_q    <= own_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ready, if_stall, dm_ready, dm_stall;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.MEM_LAT(2), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ready(dm_ready), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word = {C0DE, index}, word 16 (0x40) = 0x20090005.
    logic [31:0] mem [256];
    logic [31:0] p1, p2;
    bit          init_done;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= {16'hC0DE, 8'h00, i[7:0]};
            mem[16] <= 32'h2009_0005;
            init_done <= 1'b1;
        end else if (mem_en) begin
            p1 <= mem[mem_addr[9:2]];
            if (mem_we)
                mem[mem_addr[9:2]] <= mem_wdata;
        end
        p2 <= p1;
    end
    assign mem_rdata = p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ord;
        int n, ng, nr, last, seen;
        bit adv;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;

        // Reset state
        tick(); tick(); smp();
        chkb("rst_mem_en", mem_en, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chkb("rst_if_ready", if_ready, 1'b0);
        chkb("rst_dm_ready", dm_ready, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        tick(); rst = 1'b0; smp();

        // Single fetch at 0x40
        tick(); if_req = 1'b1; if_addr = 32'h40; smp();
        chkb("f_c0_stall", if_stall, 1'b1);
        chkb("f_c0_en", mem_en, 1'b0);
        tick(); smp();
        chkb("f_c1_en", mem_en, 1'b1);
        chk("f_c1_addr", mem_addr, 32'h40);
        chkb("f_c1_we", mem_we, 1'b0);
        chkb("f_c1_stall", if_stall, 1'b1);
        tick(); smp();
        chkb("f_c2_en", mem_en, 1'b0);
        tick(); smp();
        chkb("f_c3_ready", if_ready, 1'b0);
        chkb("f_c3_stall", if_stall, 1'b1);
        tick(); smp();
        chkb("f_c4_ready", if_ready, 1'b1);
        chk("f_c4_rdata", if_rdata, 32'h2009_0005);
        chkb("f_c4_stall", if_stall, 1'b0);
        tick(); if_req = 1'b0; smp();
        chkb("f_c5_ready", if_ready, 1'b0);
        chk("f_c5_hold", if_rdata, 32'h2009_0005);

        // Store 0xDEADBEEF to 0x100
        tick(); dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; smp();
        chkb("st_c0_stall", dm_stall, 1'b1);
        tick(); smp();
        chkb("st_c1_en", mem_en, 1'b1);
        chkb("st_c1_we", mem_we, 1'b1);
        chk("st_c1_addr", mem_addr, 32'h100);
        chk("st_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); tick(); smp();
        chkb("st_c3_ready", dm_ready, 1'b0);
        tick(); smp();
        chkb("st_c4_ready", dm_ready, 1'b1);
        chk("st_c4_rdata", dm_rdata, 32'd0);
        chkb("st_c4_stall", dm_stall, 1'b0);

        // Load back from 0x100, presented right after the store completes
        tick(); dm_we = 1'b0; dm_wdata = 32'd0; smp();
        chkb("ld_c0_ready", dm_ready, 1'b0);
        chkb("ld_c0_stall", dm_stall, 1'b1);
        tick(); smp();
        chkb("ld_c1_en", mem_en, 1'b1);
        chkb("ld_c1_we", mem_we, 1'b0);
        tick(); tick(); tick(); smp();
        chkb("ld_c4_ready", dm_ready, 1'b1);
        chk("ld_c4_rdata", dm_rdata, 32'hDEAD_BEEF);
        tick(); dm_req = 1'b0; smp();

        // Simultaneous fetch 0x80 and load 0x100: data first
        tick(); if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; smp();
        tick(); smp();
        chkb("sim_c1_en", mem_en, 1'b1);
        chk("sim_c1_addr", mem_addr, 32'h100);
        chkb("sim_c1_istall", if_stall, 1'b1);
        tick(); tick(); tick(); smp();
        chkb("sim_c4_dready", dm_ready, 1'b1);
        chkb("sim_c4_iready", if_ready, 1'b0);
        chkb("sim_c4_istall", if_stall, 1'b1);
        tick(); dm_req = 1'b0; smp();
        chkb("sim_c5_en", mem_en, 1'b0);
        chkb("sim_c5_istall", if_stall, 1'b1);
        tick(); smp();
        chkb("sim_c6_en", mem_en, 1'b1);
        chk("sim_c6_addr", mem_addr, 32'h80);
        tick(); tick(); smp();
        chkb("sim_c8_istall", if_stall, 1'b1);
        tick(); smp();
        chkb("sim_c9_iready", if_ready, 1'b1);
        chk("sim_c9_rdata", if_rdata, 32'hC0DE_0020);
        tick(); if_req = 1'b0; smp();

        // Starvation guard: both held, expect D D D D I D D D D I
        ord = 10'b0111101111;
        tick(); if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1;
        dm_addr = 32'h100; smp();
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            if (mem_en) begin
                chk($sformatf("strv_g%0d", n), mem_addr,
                    ord[n] ? 32'h100 : 32'h0);
                n++;
            end
            if (n < 10) begin
                tick(); smp();
            end
        end
        chk("strv_grants", 32'(n), 32'd10);
        tick(); if_req = 1'b0; dm_req = 1'b0; smp();
        repeat (8) tick();
        smp();

        // Reset during WAIT of a fetch to 0x8
        tick(); if_req = 1'b1; if_addr = 32'h8; smp();
        tick(); smp();
        chkb("rs_c1_en", mem_en, 1'b1);
        tick(); rst = 1'b1; if_req = 1'b0; smp();
        tick(); rst = 1'b0; smp();
        chkb("rs_mem_en", mem_en, 1'b0);
        chkb("rs_mem_we", mem_we, 1'b0);
        chk("rs_mem_addr", mem_addr, 32'd0);
        chk("rs_mem_wdata", mem_wdata, 32'd0);
        chk("rs_if_rdata", if_rdata, 32'd0);
        chk("rs_dm_rdata", dm_rdata, 32'd0);
        chkb("rs_if_ready", if_ready, 1'b0);
        chkb("rs_dm_ready", dm_ready, 1'b0);
        chkb("rs_if_stall", if_stall, 1'b0);
        seen = 0;
        repeat (6) begin
            tick(); smp();
            if (if_ready || mem_en) seen = 1;
        end
        chk("rs_quiet", 32'(seen), 32'd0);
        tick(); if_req = 1'b1; if_addr = 32'h4; smp();
        tick(); smp();
        chkb("rs2_c1_en", mem_en, 1'b1);
        chk("rs2_c1_addr", mem_addr, 32'h4);
        tick(); tick(); tick(); smp();
        chkb("rs2_c4_ready", if_ready, 1'b1);
        chk("rs2_c4_rdata", if_rdata, 32'hC0DE_0001);
        tick(); if_req = 1'b0; smp();

        // Back-to-back fetches 0x0, 0x4, 0x8 with PC advanced on if_ready
        tick(); if_req = 1'b1; if_addr = 32'h0; smp();
        ng = 0; nr = 0; last = 0;
        for (int c = 0; c < 60 && nr < 3; c++) begin
            adv = 1'b0;
            if (mem_en) begin
                chk($sformatf("b2b_addr%0d", ng), mem_addr, 32'(ng * 4));
                if (ng > 0)
                    chk($sformatf("b2b_gap%0d", ng), 32'(c - last), 32'd5);
                last = c;
                ng++;
            end
            if (if_ready) begin
                chk($sformatf("b2b_data%0d", nr), if_rdata,
                    {16'hC0DE, 16'(nr)});
                nr++;
                adv = 1'b1;
            end
            tick();
            if (adv) begin
                if (nr < 3) if_addr = if_addr + 32'd4;
                else if_req = 1'b0;
            end
            smp();
        end
        chk("b2b_readies", 32'(nr), 32'd3);
        repeat (10) begin
            if (mem_en) ng++;
            tick(); smp();
        end
        chk("b2b_issues", 32'(ng), 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
